// File: rtl/line_cmd_queue.sv
// line_cmd_queue: FIFO of line-draw commands, launched one at a time to the bresenham rasterizer.
// Latency: push into an empty idle queue gives rast_start two edges later; cmd_ready drops only when full.
// Optional LINE_SWAP_EN: endpoints are reordered on pop so the rasterizer always sees x0 <= x1.
module line_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int COORD_W = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_W-1:0]     cmd_x0,
  input  logic [COORD_W-1:0]     cmd_y0,
  input  logic [COORD_W-1:0]     cmd_x1,
  input  logic [COORD_W-1:0]     cmd_y1,
  input  logic                   flush,
  output logic [COORD_W-1:0]     rast_x0,
  output logic [COORD_W-1:0]     rast_y0,
  output logic [COORD_W-1:0]     rast_x1,
  output logic [COORD_W-1:0]     rast_y1,
  output logic                   rast_start,
  input  logic                   rast_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            lines_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } line_cmd_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE} state_t;

  line_cmd_t     mem [DEPTH];
  line_cmd_t     cmd_in;
  line_cmd_t     head;
  line_cmd_t     launch_cmd;
  line_cmd_t     rast_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  logic          done_evt;

  assign cmd_in    = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1};
  assign head      = mem[rd_ptr];
  assign cmd_ready = (count != FULL_CNT);
  // A flush cycle drops any command offered alongside it.
  assign push      = cmd_valid && cmd_ready && !flush;

  assign rast_x0 = rast_q.x0;
  assign rast_y0 = rast_q.y0;
  assign rast_x1 = rast_q.x1;
  assign rast_y1 = rast_q.y1;

  always_comb begin
    launch_cmd = head;
`ifdef LINE_SWAP_EN
    if (head.x0 > head.x1) begin
      launch_cmd.x0 = head.x1;
      launch_cmd.y0 = head.y1;
      launch_cmd.x1 = head.x0;
      launch_cmd.y1 = head.y0;
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    rast_start = 1'b0;
    busy       = 1'b0;
    done_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !flush) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        rast_start = 1'b1;
        busy       = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (rast_done) begin
          done_evt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      // Hold here while done is still high so a level-held done counts once.
      RELEASE: begin
        if (!rast_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rast_q     <= '0;
      lines_done <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      if (pop)      rast_q     <= launch_cmd;
      if (done_evt) lines_done <= lines_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_line_cmd_queue.sv
// Bench for line_cmd_queue: directed scenarios then random traffic, all outputs checked every cycle
// against a queue-based reference model.
module tb_line_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int NW    = $clog2(DEPTH) + 1;

  logic          clk       = 1'b0;
  logic          n_rst     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x0    = '0;
  logic [CW-1:0] cmd_y0    = '0;
  logic [CW-1:0] cmd_x1    = '0;
  logic [CW-1:0] cmd_y1    = '0;
  logic          flush     = 1'b0;
  logic [CW-1:0] rast_x0, rast_y0, rast_x1, rast_y1;
  logic          rast_start;
  logic          rast_done = 1'b0;
  logic          busy;
  logic [NW-1:0] count;
  logic [15:0]   lines_done;

  line_cmd_queue #(.DEPTH(DEPTH), .COORD_W(CW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .flush      (flush),
    .rast_x0    (rast_x0),
    .rast_y0    (rast_y0),
    .rast_x1    (rast_x1),
    .rast_y1    (rast_y1),
    .rast_start (rast_start),
    .rast_done  (rast_done),
    .busy       (busy),
    .count      (count),
    .lines_done (lines_done)
  );

  always #5 clk = ~clk;

  typedef logic [4*CW-1:0] cmd_t;   // {x0, y0, x1, y1}

  // Reference model: pending commands, the line on the rasterizer, and what it is doing.
  cmd_t        mq[$];
  cmd_t        m_cur;
  bit          m_start;   // launch pulse showing this cycle
  bit          m_busy;    // line owned by the rasterizer
  bit          m_drain;   // done seen, waiting for it to drop
  logic [15:0] m_lines;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  function automatic cmd_t ordered(input cmd_t c);
`ifdef LINE_SWAP_EN
    if (c[4*CW-1 -: CW] > c[2*CW-1 -: CW]) return {c[2*CW-1:0], c[4*CW-1:2*CW]};
`endif
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur   = '0;
    m_start = 1'b0;
    m_busy  = 1'b0;
    m_drain = 1'b0;
    m_lines = '0;
  endtask

  task automatic model_edge();
    bit   can_push;
    cmd_t incoming;
    if (!n_rst) begin
      model_reset();
      return;
    end
    can_push = cmd_valid && (mq.size() < DEPTH) && !flush;
    incoming = {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    if (m_start) begin
      m_start = 1'b0;
    end else if (m_busy) begin
      if (rast_done) begin
        m_busy  = 1'b0;
        m_drain = 1'b1;
        m_lines = m_lines + 16'd1;
      end
    end else if (m_drain) begin
      if (!rast_done) m_drain = 1'b0;
    end else if (mq.size() > 0 && !flush) begin
      m_cur   = ordered(mq.pop_front());
      m_busy  = 1'b1;
      m_start = 1'b1;
    end
    if (flush) mq.delete();
    else if (can_push) mq.push_back(incoming);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rast_start", 32'(rast_start), 32'(m_start));
    check("busy",       32'(busy),       32'(m_busy));
    check("count",      32'(count),      32'(mq.size()));
    check("cmd_ready",  32'(cmd_ready),  32'(mq.size() != DEPTH));
    check("lines_done", 32'(lines_done), 32'(m_lines));
    check("rast_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), 32'(m_cur));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic push_cmd(input cmd_t c);
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic done_pulse();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
  endtask

  cmd_t exp_swap;

  initial begin
    model_reset();
    #2;
    check("rst_start", 32'(rast_start), 32'd0);
    check("rst_ready", 32'(cmd_ready),  32'd1);
    check("rst_count", 32'(count),      32'd0);
    check_all();
    repeat (2) tick();
    n_rst = 1'b1;
    tick();

    // Single line: start exactly one edge after the push edge, coords held.
    push_cmd({8'd12, 8'd12, 8'd45, 8'd69});
    check("pre_start", 32'(rast_start), 32'd0);
    tick();
    check("first_start",  32'(rast_start), 32'd1);
    check("first_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), {8'd12, 8'd12, 8'd45, 8'd69});
    tick();
    check("start_one_cycle", 32'(rast_start), 32'd0);
    repeat (3) tick();
    check("held_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), {8'd12, 8'd12, 8'd45, 8'd69});
    done_pulse();
    check("first_lines", 32'(lines_done), 32'd1);
    check("first_busy",  32'(busy),       32'd0);
    repeat (2) tick();

    // Burst: fill behind an in-flight line, then a blocked sixth command.
    push_cmd({8'd1, 8'd2, 8'd3, 8'd4});
    tick();
    push_cmd({8'd5, 8'd6, 8'd7, 8'd8});
    push_cmd({8'd9, 8'd10, 8'd11, 8'd12});
    push_cmd({8'd13, 8'd14, 8'd15, 8'd16});
    push_cmd({8'd17, 8'd18, 8'd19, 8'd20});
    check("full_count", 32'(count),     32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = {8'd21, 8'd22, 8'd23, 8'd24};
    cmd_valid = 1'b1;
    repeat (3) tick();
    check("full_hold", 32'(count), 32'd4);
    done_pulse();
    cmd_valid = 1'b1;
    repeat (4) tick();
    cmd_valid = 1'b0;
    repeat (5) begin
      repeat (3) tick();
      done_pulse();
    end
    repeat (3) tick();
    check("burst_lines", 32'(lines_done), 32'd7);

    // Level-held done: one increment, next start only after done falls.
    push_cmd({8'd40, 8'd41, 8'd42, 8'd43});
    push_cmd({8'd50, 8'd51, 8'd52, 8'd53});
    repeat (2) tick();
    rast_done = 1'b1;
    repeat (6) tick();
    check("level_lines", 32'(lines_done), 32'd8);
    rast_done = 1'b0;
    repeat (4) tick();
    done_pulse();
    repeat (2) tick();

    // Flush during WAIT_DONE, with a dropped same-cycle command.
    push_cmd({8'd60, 8'd61, 8'd62, 8'd63});
    repeat (2) tick();
    push_cmd({8'd64, 8'd65, 8'd66, 8'd67});
    push_cmd({8'd68, 8'd69, 8'd70, 8'd71});
    push_cmd({8'd72, 8'd73, 8'd74, 8'd75});
    flush = 1'b1;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = {8'd99, 8'd99, 8'd99, 8'd99};
    cmd_valid = 1'b1;
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_busy",  32'(busy),  32'd1);
    repeat (2) tick();
    done_pulse();
    repeat (5) tick();
    check("flush_no_start", 32'(rast_start), 32'd0);

    // Reset mid-line with two commands queued.
    push_cmd({8'd80, 8'd81, 8'd82, 8'd83});
    repeat (2) tick();
    push_cmd({8'd84, 8'd85, 8'd86, 8'd87});
    push_cmd({8'd88, 8'd89, 8'd90, 8'd91});
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_start",  32'(rast_start), 32'd0);
    check("arst_busy",   32'(busy),       32'd0);
    check("arst_count",  32'(count),      32'd0);
    check("arst_ready",  32'(cmd_ready),  32'd1);
    check("arst_lines",  32'(lines_done), 32'd0);
    check("arst_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), 32'd0);
    model_reset();
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    check("arst_no_start", 32'(rast_start), 32'd0);

    // Endpoint ordering.
`ifdef LINE_SWAP_EN
    exp_swap = {8'd12, 8'd12, 8'd45, 8'd69};
`else
    exp_swap = {8'd45, 8'd69, 8'd12, 8'd12};
`endif
    push_cmd({8'd45, 8'd69, 8'd12, 8'd12});
    tick();
    check("swap_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), exp_swap);
    tick();
    done_pulse();
    repeat (2) tick();
    push_cmd({8'd30, 8'd5, 8'd30, 8'd60});
    tick();
    check("equal_x_coords", 32'({rast_x0, rast_y0, rast_x1, rast_y1}), {8'd30, 8'd5, 8'd30, 8'd60});
    tick();
    done_pulse();
    repeat (2) tick();

    // Random traffic: pushes, flushes and done pulses/levels in any state.
    repeat (600) begin
      cmd_valid = 1'($urandom_range(0, 1));
      {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = $urandom;
      if ($urandom_range(0, 3) == 0) cmd_x1 = cmd_x0;
      flush     = ($urandom_range(0, 15) == 0);
      rast_done = ($urandom_range(0, 2) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    flush     = 1'b0;
    rast_done = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
